// File: rtl/wrom_arbiter.sv
// Round-robin arbiter sharing one weight/bias ROM address port between NREQ requesters.
// Latency: combinational grant; data returns ROM_LATENCY+2 cycles after the grant cycle.
// Backpressure: a requester holds req until granted; one read is issued per cycle.
module wrom_arbiter #(
   parameter int NREQ        = 4,
   parameter int AW          = 6,
   parameter int DW          = 32,
   parameter int ROM_LATENCY = 1
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [NREQ-1:0]    i_req,
   input  logic [NREQ-1:0]    i_lock,
   input  logic [NREQ*AW-1:0] i_addr,
   output logic [NREQ-1:0]    o_gnt,
   output logic [NREQ-1:0]    o_rd_valid,
   output logic [DW-1:0]      o_rd_data,
   output logic               o_busy,
   output logic [AW-1:0]      o_rom_addr,
   input  logic [DW-1:0]      i_rom_data
);

   localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   // One stage covers the rom_addr register, ROM_LATENCY more cover the ROM itself.
   localparam int NSTG = ROM_LATENCY + 1;

   // Arbitration state
   logic [IW-1:0]   r_ptr;
   logic            r_lock_vld;
   logic [IW-1:0]   r_lock_idx;

   // Datapath and return state
   logic [AW-1:0]   r_rom_addr;
   logic [NREQ-1:0] r_tag [NSTG];
   logic [NREQ-1:0] r_rd_valid;
   logic [DW-1:0]   r_rd_data;
   logic            r_busy;

   // Combinational arbitration results
   logic [NREQ-1:0] w_gnt;
   logic [IW-1:0]   w_win;
   logic            w_any;
   logic            w_lock_hit;
   logic [IW-1:0]   w_ptr_nxt;
   logic            w_tags_busy;

   // Index base+off reduced modulo NREQ (off is always below NREQ).
   function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NREQ) begin
         s = s - NREQ;
      end
      return IW'(s);
   endfunction

   // Lock owner keeps the port while it requests; otherwise rotate from the pointer.
   always_comb begin
      w_gnt      = '0;
      w_win      = '0;
      w_any      = 1'b0;
      w_lock_hit = r_lock_vld && i_req[r_lock_idx];
      if (w_lock_hit) begin
         w_gnt[r_lock_idx] = 1'b1;
         w_win             = r_lock_idx;
         w_any             = 1'b1;
      end else begin
         for (int k = 0; k < NREQ; k++) begin
            if (!w_any && i_req[wrap_idx(r_ptr, k)]) begin
               w_any                      = 1'b1;
               w_win                      = wrap_idx(r_ptr, k);
               w_gnt[wrap_idx(r_ptr, k)]  = 1'b1;
            end
         end
      end
   end

   // Next pointer sits just past the winner, wrapping from NREQ-1 to 0.
   always_comb begin
      w_ptr_nxt = wrap_idx(w_win, 1);
   end

   // Busy looks at the tag pipeline as it will be after the coming edge.
   always_comb begin
      w_tags_busy = |w_gnt;
      for (int s = 0; s < NSTG - 1; s++) begin
         w_tags_busy = w_tags_busy | (|r_tag[s]);
      end
   end

   // Pointer advances on normal grants, stays put while a locked burst continues.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ptr      <= '0;
         r_lock_vld <= 1'b0;
         r_lock_idx <= '0;
      end else if (w_any) begin
         if (!w_lock_hit) begin
            r_ptr <= w_ptr_nxt;
         end
         r_lock_vld <= i_lock[w_win];
         r_lock_idx <= w_win;
      end else begin
         // No grant means the owner, if any, dropped its request.
         r_lock_vld <= 1'b0;
      end
   end

   // Winner's address goes to the ROM; the port holds its value when idle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rom_addr <= '0;
      end else if (w_any) begin
         r_rom_addr <= i_addr[w_win*AW +: AW];
      end
   end

   // One-hot requester tags travel alongside the ROM read to steer the returned word.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int s = 0; s < NSTG; s++) begin
            r_tag[s] <= '0;
         end
      end else begin
         r_tag[0] <= w_gnt;
         for (int s = 1; s < NSTG; s++) begin
            r_tag[s] <= r_tag[s-1];
         end
      end
   end

   // Capture ROM data when the matching tag reaches the end of the pipeline.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_valid <= '0;
         r_rd_data  <= '0;
         r_busy     <= 1'b0;
      end else begin
         r_busy <= w_tags_busy;
         if (|r_tag[NSTG-1]) begin
            r_rd_valid <= r_tag[NSTG-1];
            r_rd_data  <= i_rom_data;
         end else begin
            r_rd_valid <= '0;
         end
      end
   end

   assign o_gnt      = w_gnt;
   assign o_rd_valid = r_rd_valid;
   assign o_rd_data  = r_rd_data;
   assign o_busy     = r_busy;
   assign o_rom_addr = r_rom_addr;

   // Grant is at most one-hot and only ever goes to an active requester.
   a_gnt_onehot : assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(w_gnt));
   a_gnt_req    : assert property (@(posedge i_clk) disable iff (!i_rst_n) (w_gnt & ~i_req) == '0);

endmodule

// File: tb/tb_wrom_arbiter.sv
// Directed bench for wrom_arbiter: default instance plus a ROM_LATENCY=3 instance.
// Inputs change 1 time unit after the rising edge, outputs are sampled on the falling edge.
module tb_wrom_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req, lock, gnt, rd_valid;
   logic [23:0] addr;
   logic [31:0] rd_data, rom_data;
   logic        busy;
   logic [5:0]  rom_addr;

   logic [3:0]  req_l3, lock_l3, gnt_l3, rd_valid_l3;
   logic [23:0] addr_l3;
   logic [31:0] rd_data_l3, rom_data_l3;
   logic        busy_l3;
   logic [5:0]  rom_addr_l3;
   logic [31:0] rom3_pipe [3];

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [3:0]  req;
      logic [3:0]  lock;
      logic [23:0] addr;
      logic [3:0]  gnt;
      logic [3:0]  vld;
      logic [5:0]  raddr;
      logic        busy;
      logic [31:0] data;
   } vec_t;

   vec_t vq[$];

   always #5 clk = ~clk;

   wrom_arbiter #(.NREQ(4), .AW(6), .DW(32), .ROM_LATENCY(1)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_lock(lock), .i_addr(addr),
      .o_gnt(gnt), .o_rd_valid(rd_valid), .o_rd_data(rd_data), .o_busy(busy),
      .o_rom_addr(rom_addr), .i_rom_data(rom_data));

   wrom_arbiter #(.NREQ(4), .AW(6), .DW(32), .ROM_LATENCY(3)) dut_l3 (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req_l3), .i_lock(lock_l3), .i_addr(addr_l3),
      .o_gnt(gnt_l3), .o_rd_valid(rd_valid_l3), .o_rd_data(rd_data_l3), .o_busy(busy_l3),
      .o_rom_addr(rom_addr_l3), .i_rom_data(rom_data_l3));

   // ROM contents: address 36 holds 1.0f, everything else a recognisable pattern.
   function automatic logic [31:0] rom_val(input logic [5:0] a);
      if (a == 6'd36) return 32'h3F80_0000;
      return {16'hC0DE, 10'd0, a};
   endfunction

   // ROM models: one registered stage, and three registered stages.
   always @(posedge clk) begin
      rom_data     <= rom_val(rom_addr);
      rom3_pipe[0] <= rom_val(rom_addr_l3);
      rom3_pipe[1] <= rom3_pipe[0];
      rom3_pipe[2] <= rom3_pipe[1];
   end
   assign rom_data_l3 = rom3_pipe[2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic void add(input logic [3:0] r, input logic [3:0] l,
                               input logic [5:0] a0, input logic [5:0] a1,
                               input logic [5:0] a2, input logic [5:0] a3,
                               input logic [3:0] g, input logic [3:0] v,
                               input logic [5:0] ra, input logic b, input logic [31:0] d);
      vec_t e;
      e.req = r; e.lock = l; e.addr = {a3, a2, a1, a0};
      e.gnt = g; e.vld = v; e.raddr = ra; e.busy = b; e.data = d;
      vq.push_back(e);
   endfunction

   task automatic do_reset();
      req = '0; lock = '0; addr = '0;
      req_l3 = '0; lock_l3 = '0; addr_l3 = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Watchdog: the bench uses only fixed cycle counts, this guards against a stuck clock.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // ---------------- reset state ----------------
      do_reset();
      chk("reset rom_addr", 32'(rom_addr), 32'd0);
      chk("reset rd_valid", 32'(rd_valid), 32'd0);
      chk("reset rd_data", rd_data, 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset gnt", 32'(gnt), 32'd0);

      // ---------------- single read of ROM[36] ----------------
      step(); req = 4'b0001; addr = {6'd0, 6'd0, 6'd0, 6'd36};
      @(negedge clk); chk("single t gnt", 32'(gnt), 32'h1);
      step(); req = '0;
      @(negedge clk);
      chk("single t+1 rom_addr", 32'(rom_addr), 32'd36);
      chk("single t+1 busy", 32'(busy), 32'd1);
      chk("single t+1 rd_valid", 32'(rd_valid), 32'd0);
      step(); @(negedge clk);
      chk("single t+2 busy", 32'(busy), 32'd1);
      chk("single t+2 rd_valid", 32'(rd_valid), 32'd0);
      step(); @(negedge clk);
      chk("single t+3 rd_valid", 32'(rd_valid), 32'h1);
      chk("single t+3 rd_data", rd_data, 32'h3F80_0000);
      chk("single t+3 busy", 32'(busy), 32'd0);
      step(); @(negedge clk);
      chk("single t+4 rd_valid", 32'(rd_valid), 32'd0);

      // ---------------- table: rotation, wrap, lock burst ----------------
      // req lock a0 a1 a2 a3 | gnt vld rom_addr busy rd_data
      // full rotation from pointer 0, addresses 10/20/30/40
      add(4'hF, 4'h0, 10, 20, 30, 40, 4'h1, 4'h0,  0, 0, 32'h0);
      add(4'hF, 4'h0, 10, 20, 30, 40, 4'h2, 4'h0, 10, 1, 32'h0);
      add(4'hF, 4'h0, 10, 20, 30, 40, 4'h4, 4'h0, 20, 1, 32'h0);
      add(4'hF, 4'h0, 10, 20, 30, 40, 4'h8, 4'h1, 30, 1, rom_val(10));
      add(4'hF, 4'h0, 10, 20, 30, 40, 4'h1, 4'h2, 40, 1, rom_val(20));
      add(4'hF, 4'h0, 10, 20, 30, 40, 4'h2, 4'h4, 10, 1, rom_val(30));
      add(4'hF, 4'h0, 10, 20, 30, 40, 4'h4, 4'h8, 20, 1, rom_val(40));
      add(4'hF, 4'h0, 10, 20, 30, 40, 4'h8, 4'h1, 30, 1, rom_val(10));
      add(4'h0, 4'h0, 10, 20, 30, 40, 4'h0, 4'h2, 40, 1, rom_val(20));
      add(4'h0, 4'h0, 10, 20, 30, 40, 4'h0, 4'h4, 40, 1, rom_val(30));
      add(4'h0, 4'h0, 10, 20, 30, 40, 4'h0, 4'h8, 40, 0, rom_val(40));
      add(4'h0, 4'h0, 10, 20, 30, 40, 4'h0, 4'h0, 40, 0, rom_val(40));
      // grant 2 moves pointer to 3; req=1001 picks 3, then wraps to 0
      add(4'h4, 4'h0, 10, 20, 30, 40, 4'h4, 4'h0, 40, 0, rom_val(40));
      add(4'h9, 4'h0, 10, 20, 30, 40, 4'h8, 4'h0, 30, 1, rom_val(40));
      add(4'h1, 4'h0, 10, 20, 30, 40, 4'h1, 4'h0, 40, 1, rom_val(40));
      add(4'h0, 4'h0, 10, 20, 30, 40, 4'h0, 4'h4, 10, 1, rom_val(30));
      add(4'h0, 4'h0, 10, 20, 30, 40, 4'h0, 4'h8, 10, 1, rom_val(40));
      add(4'h0, 4'h0, 10, 20, 30, 40, 4'h0, 4'h1, 10, 0, rom_val(10));
      add(4'h0, 4'h0, 10, 20, 30, 40, 4'h0, 4'h0, 10, 0, rom_val(10));
      // requester 1 locks a burst 44..47; requester 0/2 addresses wiggle unused
      add(4'h7, 4'h2, 10, 44, 30, 40, 4'h2, 4'h0, 10, 0, rom_val(10));
      add(4'h7, 4'h2,  5, 45, 30, 40, 4'h2, 4'h0, 44, 1, rom_val(10));
      add(4'h7, 4'h2,  6, 46, 30, 40, 4'h2, 4'h0, 45, 1, rom_val(10));
      add(4'h7, 4'h2,  7, 47, 30, 40, 4'h2, 4'h2, 46, 1, rom_val(44));
      // requester 1 drops req: lock released, pointer (2) picks 2 over 0
      add(4'h5, 4'h0,  8, 48, 30, 40, 4'h4, 4'h2, 47, 1, rom_val(45));
      add(4'h1, 4'h0,  8, 48, 30, 40, 4'h1, 4'h2, 30, 1, rom_val(46));
      add(4'h0, 4'h0,  8, 48, 30, 40, 4'h0, 4'h2,  8, 1, rom_val(47));
      add(4'h0, 4'h0,  8, 48, 30, 40, 4'h0, 4'h4,  8, 1, rom_val(30));
      add(4'h0, 4'h0,  8, 48, 30, 40, 4'h0, 4'h1,  8, 0, rom_val(8));
      add(4'h0, 4'h0,  8, 48, 30, 40, 4'h0, 4'h0,  8, 0, rom_val(8));

      do_reset();
      for (int i = 0; i < vq.size(); i++) begin
         step();
         req = vq[i].req; lock = vq[i].lock; addr = vq[i].addr;
         @(negedge clk);
         chk($sformatf("row%0d gnt", i), 32'(gnt), 32'(vq[i].gnt));
         chk($sformatf("row%0d rd_valid", i), 32'(rd_valid), 32'(vq[i].vld));
         chk($sformatf("row%0d rom_addr", i), 32'(rom_addr), 32'(vq[i].raddr));
         chk($sformatf("row%0d busy", i), 32'(busy), 32'(vq[i].busy));
         chk($sformatf("row%0d rd_data", i), rd_data, vq[i].data);
      end

      // ---------------- reset with two reads in flight ----------------
      // pointer is at 1 here
      step(); req = 4'b1000; addr = {6'd40, 6'd30, 6'd20, 6'd10};
      @(negedge clk); chk("flush grant a", 32'(gnt), 32'h8);
      step(); req = 4'b0001;
      @(negedge clk); chk("flush grant b", 32'(gnt), 32'h1);
      step(); req = '0; rst_n = 1'b0;
      @(negedge clk);
      chk("flush in reset busy", 32'(busy), 32'd0);
      chk("flush in reset rom_addr", 32'(rom_addr), 32'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step(); @(negedge clk);
         chk($sformatf("flush c%0d rd_valid", k), 32'(rd_valid), 32'd0);
         chk($sformatf("flush c%0d busy", k), 32'(busy), 32'd0);
         chk($sformatf("flush c%0d rom_addr", k), 32'(rom_addr), 32'd0);
      end

      // ---------------- ROM_LATENCY=3 instance, single read ----------------
      step(); req_l3 = 4'b0100; addr_l3 = {6'd0, 6'd33, 6'd0, 6'd0};
      @(negedge clk); chk("l3 gnt", 32'(gnt_l3), 32'h4);
      step(); req_l3 = '0;
      for (int k = 1; k <= 6; k++) begin
         if (k > 1) step();
         @(negedge clk);
         chk($sformatf("l3 t+%0d rd_valid", k), 32'(rd_valid_l3), (k == 5) ? 32'h4 : 32'h0);
         chk($sformatf("l3 t+%0d busy", k), 32'(busy_l3), (k <= 4) ? 32'd1 : 32'd0);
         if (k == 5) chk("l3 rd_data", rd_data_l3, rom_val(6'd33));
      end
      chk("l3 rom_addr", 32'(rom_addr_l3), 32'd33);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/wrom_arbiter.md
Name: wrom_arbiter

Overview:
- Round-robin arbiter that shares the single weight/bias ROM between the layer compute units (layer-1 neurons, layer-2 unit, sigmoid/bias fetch).
- Each requester issues single-word reads. The arbiter serialises them onto one ROM address port at up to one read per cycle and returns each word to its own requester with a fixed, known latency.
- Sits between the layer FSMs and the ROM megafunction; replaces per-unit private address registers.

Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 6, ROM address width
- DW, 32, ROM data width (IEEE-754 single)
- ROM_LATENCY, 1, clock edges from rom_addr change to valid rom_data (1..4)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester read request, level; held until granted
- lock  in  NREQ  per-requester burst lock; sampled with req
- addr  in  NREQ*AW  flattened addresses; requester i uses bits [i*AW +: AW]
- gnt  out  NREQ  one-hot grant, combinational from req/lock/pointer state; a cycle with gnt[i]=1 consumes the read
- rd_valid  out  NREQ  registered one-hot, 1-cycle pulse returning data to requester i
- rd_data  out  DW  registered read data, qualified by rd_valid
- busy  out  1  registered; 1 while any read is in flight
- rom_addr  out  AW  registered ROM address
- rom_data  in  DW  ROM read data

Behaviour:
- Reset is asynchronous and active-low on rst_n; single clock domain clk.
- Reset values: rom_addr=0, rd_valid=0, rd_data=0, busy=0, pointer=0, lock owner=none, in-flight tag pipeline cleared.
- Reset mid-operation flushes all in-flight reads; no rd_valid is produced for them after reset release.

Arbitration (combinational, every cycle):
- If a lock owner L exists and req[L]=1: gnt=onehot(L).
- Otherwise: scan req starting at index pointer, upward with wrap modulo NREQ; the first requester with req=1 wins.
- When req=0, gnt=0.
- At most one gnt bit is ever set; gnt never asserts for a requester whose req=0.

On each edge with a grant to w:
- rom_addr <= addr[w].
- Tag pipeline stage 0 <= onehot(w).
- pointer <= (w+1) mod NREQ, except while a lock burst is continuing, when pointer is unchanged.
- Lock owner <= w if lock[w]=1, else cleared.
- Lock owner is also cleared whenever req[owner]=0 in a cycle.

With no grant:
- rom_addr holds its value; tag stage 0 <= 0.

Pipeline and return:
- The tag pipeline is ROM_LATENCY+1 stages deep and shifts every cycle.
- When the last stage is nonzero: rd_valid <= last stage, rd_data <= rom_data. Otherwise rd_valid <= 0 and rd_data holds.
- Latency is fixed: a grant in cycle t gives rd_valid in cycle t+ROM_LATENCY+2. With the default this is t+3.
- Throughput is one read per cycle; back-to-back grants return back-to-back pulses in grant order.
- busy <= 1 when any tag stage is nonzero after the edge.

Requester rules:
- A requester may hold req high across cycles to issue consecutive reads.
- Each cycle with gnt[i]=1 is one read of the addr[i] value present in that cycle.
- The requester updates addr on the edge following a grant, mirroring the old rom_addr+1 stepping.
- Multiple outstanding reads per requester are allowed; data returns in order.

Boundary conditions:
- Pointer wraps from NREQ-1 to 0.
- All requesters active: strict rotation 0,1,2,3,0…; no requester waits more than NREQ-1 grants.
- Locked requester drops req: lock released that cycle and arbitration proceeds normally in the same cycle.
- lock without req is ignored.
- addr changing while not granted has no effect.

Test Plan:
- Reset, then req=0001, addr0=36, ROM[36]=0x3F800000 -> gnt=0001 in cycle t; rom_addr=36 in t+1; rd_valid=0001, rd_data=0x3F800000 in t+3; busy=1 in t+1..t+2.
- req=1111 held 8 cycles, addresses fixed 10/20/30/40 -> grants rotate 0,1,2,3,0,1,2,3; rd_valid pulses follow the same order 3 cycles later with ROM[10], ROM[20], ROM[30], ROM[40] twice.
- Pointer at 3 after a grant to 2, req=1001 -> grant 3 first, then 0 (wrap verified).
- lock[1]=1 with req=0111, requester 1 stepping addr 44..47 for 4 cycles -> four consecutive gnt=0010 and returns ROM[44..47]; requester 1 drops req -> next grant goes to 2.
- Assert rst_n=0 one cycle after two grants, release -> no rd_valid pulses afterwards, rom_addr=0, busy=0.
- Parameter run ROM_LATENCY=3, single read -> rd_valid exactly 5 cycles after grant.
